// File: rtl/alu_mul_seq.sv
// alu_mul_seq: 8x8 -> 16-bit shift-add multiply sequencer that time-shares an external 8-bit ALU.
// Optional two's-complement mode (sgn port, CORR1/CORR2 states) enabled by defining ALU_MUL_SEQ_SIGNED_EN.
module alu_mul_seq #(
    parameter int unsigned ITER = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
`ifdef ALU_MUL_SEQ_SIGNED_EN
    input  logic        sgn,
`endif
    input  logic [7:0]  op_a,
    input  logic [7:0]  op_b,
    output logic        busy,
    output logic        done,
    output logic [15:0] product,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_ci,
    output logic        alu_nb,
    output logic        alu_ic,
    output logic        alu_na,
    output logic        alu_xo,
    output logic        alu_no,
    output logic        alu_sr,
    output logic        alu_ss,
    input  logic [7:0]  alu_out,
    input  logic        alu_cf
);

    localparam int unsigned DW = 8;
    localparam int unsigned CW = $clog2(ITER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADD,
        S_SHIFT,
        S_CORR1,
        S_CORR2,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [DW-1:0]   r_m;
    logic [DW-1:0]   r_p_hi;
    logic [DW-1:0]   r_p_lo;
    logic [CW-1:0]   r_cnt;
    logic            r_c;
    logic [2*DW-1:0] r_product;
    logic [DW-1:0]   w_m_nxt;
    logic [DW-1:0]   w_p_hi_nxt;
    logic [DW-1:0]   w_p_lo_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_c_nxt;
`ifdef ALU_MUL_SEQ_SIGNED_EN
    logic [DW-1:0]   r_b;
    logic            r_sgn;
`endif

    // State and datapath registers; product captures the final value on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_m       <= '0;
            r_p_hi    <= '0;
            r_p_lo    <= '0;
            r_cnt     <= '0;
            r_c       <= 1'b0;
            r_product <= '0;
`ifdef ALU_MUL_SEQ_SIGNED_EN
            r_b       <= '0;
            r_sgn     <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_m     <= w_m_nxt;
            r_p_hi  <= w_p_hi_nxt;
            r_p_lo  <= w_p_lo_nxt;
            r_cnt   <= w_cnt_nxt;
            r_c     <= w_c_nxt;
            if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
                r_product <= {w_p_hi_nxt, w_p_lo_nxt};
            end
`ifdef ALU_MUL_SEQ_SIGNED_EN
            if ((r_state == S_IDLE) && start) begin
                r_b   <= op_b;
                r_sgn <= sgn;
            end
`endif
        end
    end

    // Next-state, datapath updates and ALU operand/control drive
    always_comb begin
        w_state_nxt = r_state;
        w_m_nxt     = r_m;
        w_p_hi_nxt  = r_p_hi;
        w_p_lo_nxt  = r_p_lo;
        w_cnt_nxt   = r_cnt;
        w_c_nxt     = r_c;
        alu_a       = '0;
        alu_b       = '0;
        alu_ci      = 1'b0;
        alu_nb      = 1'b0;
        alu_ic      = 1'b0;
        alu_na      = 1'b0;
        alu_xo      = 1'b0;
        alu_no      = 1'b0;
        alu_sr      = 1'b0;
        alu_ss      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_m_nxt     = op_a;
                    w_p_lo_nxt  = op_b;
                    w_p_hi_nxt  = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_ADD;
                end
            end
            S_ADD: begin
                alu_a       = r_p_hi;
                alu_b       = r_p_lo[0] ? r_m : '0;
                w_p_hi_nxt  = alu_out;
                w_c_nxt     = alu_cf;
                w_state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                // ALU gives P_hi>>1; the saved add carry refills the msb
                alu_a      = r_p_hi;
                alu_ic     = 1'b1;
                alu_sr     = 1'b1;
                w_p_hi_nxt = {r_c, alu_out[DW-2:0]};
                w_p_lo_nxt = {r_p_hi[0], r_p_lo[DW-1:1]};
                w_cnt_nxt  = r_cnt + CW'(1);
                if (r_cnt == CW'(ITER - 1)) begin
`ifdef ALU_MUL_SEQ_SIGNED_EN
                    w_state_nxt = r_sgn ? S_CORR1 : S_DONE;
`else
                    w_state_nxt = S_DONE;
`endif
                end else begin
                    w_state_nxt = S_ADD;
                end
            end
`ifdef ALU_MUL_SEQ_SIGNED_EN
            S_CORR1: begin
                alu_a       = r_p_hi;
                alu_b       = r_m[DW-1] ? r_b : '0;
                alu_nb      = 1'b1;
                alu_ci      = 1'b1;
                w_p_hi_nxt  = alu_out;
                w_state_nxt = S_CORR2;
            end
            S_CORR2: begin
                alu_a       = r_p_hi;
                alu_b       = r_b[DW-1] ? r_m : '0;
                alu_nb      = 1'b1;
                alu_ci      = 1'b1;
                w_p_hi_nxt  = alu_out;
                w_state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy    = (r_state == S_ADD) || (r_state == S_SHIFT) ||
                     (r_state == S_CORR1) || (r_state == S_CORR2);
    assign done    = (r_state == S_DONE);
    assign product = r_product;

endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: scoreboard bench for alu_mul_seq with a behavioural model of the external ALU.
module tb_alu_mul_seq;

`ifdef ALU_MUL_SEQ_SIGNED_EN
    localparam bit SGN_ON = 1'b1;
`else
    localparam bit SGN_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_ci, alu_nb, alu_ic, alu_na, alu_xo, alu_no, alu_sr, alu_ss;
    logic [7:0]  alu_out;
    logic        alu_cf;
    logic [7:0]  ctl;

    typedef struct {
        logic [15:0] exp;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sg;
        int          acc;
    } txn_t;

    txn_t        q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [15:0] last_product = '0;
    int          m_k;
    int          m_lat;
    logic [7:0]  a_e;
    logic [7:0]  b_e;
    logic [8:0]  sum;

    alu_mul_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
`ifdef ALU_MUL_SEQ_SIGNED_EN
        .sgn     (sgn),
`endif
        .op_a    (op_a),
        .op_b    (op_b),
        .busy    (busy),
        .done    (done),
        .product (product),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_ci  (alu_ci),
        .alu_nb  (alu_nb),
        .alu_ic  (alu_ic),
        .alu_na  (alu_na),
        .alu_xo  (alu_xo),
        .alu_no  (alu_no),
        .alu_sr  (alu_sr),
        .alu_ss  (alu_ss),
        .alu_out (alu_out),
        .alu_cf  (alu_cf)
    );

    assign ctl = {alu_ci, alu_nb, alu_ic, alu_na, alu_xo, alu_no, alu_sr, alu_ss};

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // External ALU: optional operand inversion, add with carry-in, or right shift of a
    always_comb begin
        a_e = alu_na ? ~alu_a : alu_a;
        b_e = alu_nb ? ~alu_b : alu_b;
        sum = {1'b0, a_e} + {1'b0, b_e} + {8'b0, alu_ci};
        if (alu_sr) begin
            alu_out = {alu_ss & alu_a[7], alu_a[7:1]};
            alu_cf  = alu_a[0];
        end else if (alu_xo) begin
            alu_out = a_e ^ b_e;
            alu_cf  = 1'b0;
        end else begin
            alu_out = sum[7:0];
            alu_cf  = sum[8];
        end
        if (alu_no) alu_out = ~alu_out;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic sg);
        logic [15:0] ea;
        logic [15:0] eb;
        ea = sg ? {{8{a[7]}}, a} : {8'h00, a};
        eb = sg ? {{8{b[7]}}, b} : {8'h00, b};
        return ea * eb;
    endfunction

    // Monitor: per-cycle phase checks and scoreboard pop on done
    always @(negedge clk) begin
        if (!rst) begin
            if (q.size() != 0) begin
                m_k   = cyc - q[0].acc;
                m_lat = q[0].sg ? 19 : 17;
                if (m_k == m_lat) begin
                    chk("done_pulse", 32'(done), 32'd1);
                    chk("busy_in_done", 32'(busy), 32'd0);
                    chk("product", 32'(product), 32'(q[0].exp));
                    chk("ctl_in_done", 32'(ctl), 32'd0);
                    last_product = q[0].exp;
                    void'(q.pop_front());
                end else begin
                    chk("done_early", 32'(done), 32'd0);
                    chk("product_hold", 32'(product), 32'(last_product));
                    if (m_k >= 1 && m_k <= 16) begin
                        chk("busy", 32'(busy), 32'd1);
                        if (m_k % 2 == 1) begin
                            chk("add_b", 32'(alu_b), q[0].b[(m_k - 1) / 2] ? 32'(q[0].a) : 32'd0);
                            chk("add_ctl", 32'(ctl), 32'd0);
                        end else begin
                            chk("shift_b", 32'(alu_b), 32'd0);
                            chk("shift_ctl", 32'(ctl), 32'h22);
                        end
                    end else if (m_k == 17 || m_k == 18) begin
                        chk("corr_busy", 32'(busy), 32'd1);
                        chk("corr_ctl", 32'(ctl), 32'hC0);
                        if (m_k == 17)
                            chk("corr1_b", 32'(alu_b), q[0].a[7] ? 32'(q[0].b) : 32'd0);
                        else
                            chk("corr2_b", 32'(alu_b), q[0].b[7] ? 32'(q[0].a) : 32'd0);
                    end
                end
            end else begin
                chk("idle_done", 32'(done), 32'd0);
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_product", 32'(product), 32'(last_product));
                chk("idle_alu", {8'h00, alu_a, alu_b, ctl}, 32'd0);
            end
        end
    end

    // Called at posedge+1 while the DUT is in IDLE; start is sampled at the next edge
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic sg);
        txn_t t;
        op_a  = a;
        op_b  = b;
        sgn   = sg;
        start = 1'b1;
        t.a   = a;
        t.b   = b;
        t.sg  = sg & SGN_ON;
        t.exp = ref_mul(a, b, t.sg);
        t.acc = cyc;
        q.push_back(t);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 32'(q.size()), 32'd0);
        q.delete();
    endtask

    initial begin
        txn_t t;
        rst   = 1'b1;
        start = 1'b0;
        sgn   = 1'b0;
        op_a  = '0;
        op_b  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_alu", {8'h00, alu_a, alu_b, ctl}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        start_op(8'd13, 8'd11, 1'b0);
        wait_idle(40);
        start_op(8'hFF, 8'hFF, 1'b0);
        wait_idle(40);
        start_op(8'h5A, 8'h00, 1'b0);
        wait_idle(40);

        // start held through a whole run with operands changing after accept
        op_a  = 8'd7;
        op_b  = 8'd9;
        start = 1'b1;
        t.a = 8'd7; t.b = 8'd9; t.sg = 1'b0; t.exp = ref_mul(8'd7, 8'd9, 1'b0); t.acc = cyc;
        q.push_back(t);
        @(posedge clk);
        #1;
        op_a = 8'h33;
        op_b = 8'h44;
        wait_idle(40);
        chk("held_idle_busy", 32'(busy), 32'd0);
        t.a = 8'h33; t.b = 8'h44; t.sg = 1'b0; t.exp = ref_mul(8'h33, 8'h44, 1'b0); t.acc = cyc;
        q.push_back(t);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("held_reaccept_busy", 32'(busy), 32'd1);
        wait_idle(40);

        // reset in the fifth cycle of an operation abandons it
        start_op(8'hAB, 8'hCD, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        last_product = '0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_product", 32'(product), 32'd0);
        chk("midrst_alu", {8'h00, alu_a, alu_b, ctl}, 32'd0);
        repeat (20) @(posedge clk);
        #1;
        start_op(8'd2, 8'd3, 1'b0);
        wait_idle(40);

        for (int i = 0; i < 4; i++) begin
            start_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);
            wait_idle(40);
        end

`ifdef ALU_MUL_SEQ_SIGNED_EN
        start_op(8'hFD, 8'h05, 1'b1);
        wait_idle(40);
        start_op(8'h80, 8'h80, 1'b1);
        wait_idle(40);
        start_op(8'hFD, 8'h05, 1'b0);
        wait_idle(40);
        start_op(8'h7F, 8'h81, 1'b1);
        wait_idle(40);
`endif

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
